// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator (hpos/vpos, syncs, display enable,
// line/frame strobes, frame counter). Defaults give 640x480@60 Hz on an
// 800x525 raster. Every output is a flop; sync/enable/strobes are computed
// from the next-state counters so they always describe the presented hpos/vpos.
// Optional macro VGA_SYNC_DELAY_EN adds one extra register stage on hsync,
// vsync and display_on so they lag hpos/vpos by one clock.
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // Counters are 10 bits wide, so neither raster dimension may exceed 1024.
  if (H_TOTAL > 1024) begin : g_h_total_chk
    $error("vga_timing_gen: H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > 1024) begin : g_v_total_chk
    $error("vga_timing_gen: V_TOTAL exceeds 1024");
  end

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  // Range bounds are 11 bits so an end bound of 1024 is still representable.
  localparam logic [10:0] H_DISP_E = 11'(H_DISPLAY);
  localparam logic [10:0] V_DISP_E = 11'(V_DISPLAY);
  localparam logic [10:0] HS_START = 11'(H_DISPLAY + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_DISPLAY + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [9:0] hpos_q, hpos_d;
  logic [9:0] vpos_q, vpos_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       display_on_q, display_on_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic [7:0] frame_count_q, frame_count_d;
  logic [10:0] h_ext_s;
  logic [10:0] v_ext_s;

  // Next-state counters, then every flag derived from those next values.
  always_comb begin
    hpos_d = hpos_q;
    vpos_d = vpos_q;
    if (hpos_q == H_LAST) begin
      hpos_d = 10'd0;
      if (vpos_q == V_LAST) begin
        vpos_d = 10'd0;
      end else begin
        vpos_d = vpos_q + 10'd1;
      end
    end else begin
      hpos_d = hpos_q + 10'd1;
      vpos_d = vpos_q;
    end
    h_ext_s = {1'b0, hpos_d};
    v_ext_s = {1'b0, vpos_d};
    hsync_d = ((h_ext_s >= HS_START) && (h_ext_s < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d = ((v_ext_s >= VS_START) && (v_ext_s < VS_END)) ? SYNC_POL : ~SYNC_POL;
    display_on_d  = (h_ext_s < H_DISP_E) && (v_ext_s < V_DISP_E);
    line_start_d  = (hpos_d == 10'd0);
    frame_start_d = (hpos_d == 10'd0) && (vpos_d == 10'd0);
    frame_count_d = frame_start_d ? (frame_count_q + 8'd1) : frame_count_q;
  end

  // State and output registers; reset parks the raster on its last pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos_q        <= H_LAST;
      vpos_q        <= V_LAST;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      display_on_q  <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= 8'hFF;
    end else begin
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      display_on_q  <= display_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

`ifdef VGA_SYNC_DELAY_EN
  logic hsync_dly_q;
  logic vsync_dly_q;
  logic display_on_dly_q;

  // Extra stage aligning sync/enable with a registered colour pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_dly_q      <= ~SYNC_POL;
      vsync_dly_q      <= ~SYNC_POL;
      display_on_dly_q <= 1'b0;
    end else begin
      hsync_dly_q      <= hsync_q;
      vsync_dly_q      <= vsync_q;
      display_on_dly_q <= display_on_q;
    end
  end

  assign hsync      = hsync_dly_q;
  assign vsync      = vsync_dly_q;
  assign display_on = display_on_dly_q;
`else
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign display_on = display_on_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: a default 800x525 instance and a tiny
// 14x7 raster instance share clock and reset. A reference model derives
// every output from the number of clocks since reset release with plain
// arithmetic; expectations are queued per clock and a monitor compares.
module tb_vga_timing_gen;

  typedef struct {
    int hd, hf, hs, hb, vd, vf, vs, vb;
  } cfg_t;

  typedef struct {
    int hpos, vpos, fc;
    bit hs, vs, de, ls, fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [9:0] a_hpos, a_vpos, b_hpos, b_vpos;
  logic       a_hs, a_vs, a_de, a_ls, a_fs;
  logic       b_hs, b_vs, b_de, b_ls, b_fs;
  logic [7:0] a_fc, b_fc;

  int tests = 0;
  int fails = 0;
  longint t_cyc = -1;

  cfg_t cfg_a = '{640, 16, 96, 48, 480, 10, 2, 33};
  cfg_t cfg_b = '{8, 2, 2, 2, 4, 1, 1, 1};

  exp_t qa[$];
  exp_t qb[$];

  vga_timing_gen dut_a (
    .clk(clk), .rst_n(rst_n), .hpos(a_hpos), .vpos(a_vpos),
    .hsync(a_hs), .vsync(a_vs), .display_on(a_de), .line_start(a_ls),
    .frame_start(a_fs), .frame_count(a_fc)
  );

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_POL(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .hpos(b_hpos), .vpos(b_vpos),
    .hsync(b_hs), .vsync(b_vs), .display_on(b_de), .line_start(b_ls),
    .frame_start(b_fs), .frame_count(b_fc)
  );

  always #5 clk = ~clk;

  // Undelayed outputs t clocks after reset release (t<0: in reset).
  function automatic exp_t raw(input longint t, input cfg_t c);
    exp_t e;
    longint ht, vt, line;
    ht = c.hd + c.hf + c.hs + c.hb;
    vt = c.vd + c.vf + c.vs + c.vb;
    if (t < 0) begin
      e.hpos = int'(ht - 1); e.vpos = int'(vt - 1); e.fc = 255;
      e.hs = 1'b1; e.vs = 1'b1; e.de = 1'b0; e.ls = 1'b0; e.fs = 1'b0;
    end else begin
      e.hpos = int'(t % ht);
      line   = t / ht;
      e.vpos = int'(line % vt);
      e.fc   = int'((line / vt) % 256);
      e.hs = !((e.hpos >= c.hd + c.hf) && (e.hpos < c.hd + c.hf + c.hs));
      e.vs = !((e.vpos >= c.vd + c.vf) && (e.vpos < c.vd + c.vf + c.vs));
      e.de = (e.hpos < c.hd) && (e.vpos < c.vd);
      e.ls = (e.hpos == 0);
      e.fs = (e.hpos == 0) && (e.vpos == 0);
    end
    return e;
  endfunction

  function automatic exp_t expected(input longint t, input cfg_t c);
    exp_t e;
    e = raw(t, c);
`ifdef VGA_SYNC_DELAY_EN
    begin
      exp_t p;
      p = raw(t - 1, c);
      e.hs = p.hs; e.vs = p.vs; e.de = p.de;
    end
`endif
    return e;
  endfunction

  task automatic check(input string nm, input exp_t e, input logic [9:0] hp,
                       input logic [9:0] vp, input logic hs, input logic vs,
                       input logic de, input logic ls, input logic fs,
                       input logic [7:0] fc);
    tests++;
    if (hp !== 10'(e.hpos) || vp !== 10'(e.vpos) || hs !== e.hs || vs !== e.vs ||
        de !== e.de || ls !== e.ls || fs !== e.fs || fc !== 8'(e.fc)) begin
      fails++;
      $display("FAIL %s t=%0d act h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d exp h=%0d v=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d",
               nm, t_cyc, hp, vp, hs, vs, de, ls, fs, fc,
               e.hpos, e.vpos, e.hs, e.vs, e.de, e.ls, e.fs, e.fc);
    end
  endtask

  // Model side: each active edge queues the response both DUTs owe.
  initial forever begin
    @(posedge clk);
    if (!rst_n) t_cyc = -1;
    else        t_cyc = t_cyc + 1;
    qa.push_back(expected(t_cyc, cfg_a));
    qb.push_back(expected(t_cyc, cfg_b));
  end

  // Monitor side: compare each presented output against the queue head.
  initial forever begin
    @(negedge clk);
    if (qa.size() > 0) check("dut_a_cycle", qa.pop_front(), a_hpos, a_vpos, a_hs, a_vs, a_de, a_ls, a_fs, a_fc);
    if (qb.size() > 0) check("dut_b_cycle", qb.pop_front(), b_hpos, b_vpos, b_hs, b_vs, b_de, b_ls, b_fs, b_fc);
  end

  initial begin
    int hs_low;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_hold_a", expected(-1, cfg_a), a_hpos, a_vpos, a_hs, a_vs, a_de, a_ls, a_fs, a_fc);
    check("rst_hold_b", expected(-1, cfg_b), b_hpos, b_vpos, b_hs, b_vs, b_de, b_ls, b_fs, b_fc);
    @(negedge clk);
    rst_n = 1'b1;

    // First full line of the default raster: count active-low hsync clocks.
    hs_low = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      #1;
      if (a_hs == 1'b0) hs_low++;
    end
    tests++;
    if (hs_low != 96) begin
      fails++;
      $display("FAIL hsync_width act=%0d exp=%0d", hs_low, 96);
    end

    // Enough clocks for the tiny raster to wrap frame_count past 255.
    repeat (257 * 98 + 5) @(posedge clk);

    // Random asynchronous resets between edges, then restart.
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(400, 50)) @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_a", expected(-1, cfg_a), a_hpos, a_vpos, a_hs, a_vs, a_de, a_ls, a_fs, a_fc);
      check("async_rst_b", expected(-1, cfg_b), b_hpos, b_vpos, b_hs, b_vs, b_de, b_ls, b_fs, b_fc);
      repeat ($urandom_range(3, 1)) @(negedge clk);
      rst_n = 1'b1;
      repeat (300) @(posedge clk);
    end

    repeat (2) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
